// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
// Shares the register file's single write port between the ALU and memory
// writeback requesters. A round-robin arbiter feeds a one-deep registered
// write stage. A 32-entry busy scoreboard tells decode which registers still
// have writes in flight. XZR (ZR_ADDR) is never written and is never busy.
module regfile_write_scheduler #(
   parameter int WORD    = 64,
   parameter int ZR_ADDR = 31
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            req0_valid,
   input  logic [4:0]      req0_addr,
   input  logic [WORD-1:0] req0_data,
   output logic            req0_ready,

   input  logic            req1_valid,
   input  logic [4:0]      req1_addr,
   input  logic [WORD-1:0] req1_data,
   output logic            req1_ready,

   output logic [4:0]      rf_write_register,
   output logic [WORD-1:0] rf_write_data,
   output logic            rf_reg_write,

   input  logic            mark_valid,
   input  logic [4:0]      mark_addr,
   input  logic [4:0]      query_a_addr,
   input  logic [4:0]      query_b_addr,
   output logic            busy_a,
   output logic            busy_b
);

   typedef enum logic {
      WRITE_IDLE  = 1'b0,
      WRITE_ISSUE = 1'b1
   } write_state_t;

   localparam logic [4:0] ZR = 5'(ZR_ADDR);

   // Arbiter pointer: index of the requester granted most recently
   logic            last_q, last_d;

   // Write stage
   write_state_t    state_q, state_d;
   logic [4:0]      wr_addr_q, wr_addr_d;
   logic [WORD-1:0] wr_data_q, wr_data_d;

   // Pending-write scoreboard
   logic [31:0]     busy_q, busy_d;

   logic            grant0, grant1;
   logic            xfer0, xfer1;
   logic [4:0]      sel_addr;
   logic [WORD-1:0] sel_data;
   logic            sel_write;

   // Round-robin grant: a lone requester always wins, contention goes to the one not served last
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0 = last_q;
         grant1 = !last_q;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Handshake completion and pointer update; pointer holds when nothing transfers
   always_comb begin
      xfer0  = req0_valid && grant0;
      xfer1  = req1_valid && grant1;
      last_d = last_q;
      if (xfer0) begin
         last_d = 1'b0;
      end else if (xfer1) begin
         last_d = 1'b1;
      end
   end

   // Write-stage next state: issue a pulse for every accepted non-XZR transfer
   always_comb begin
      sel_addr  = req0_addr;
      sel_data  = req0_data;
      if (xfer1) begin
         sel_addr = req1_addr;
         sel_data = req1_data;
      end
      sel_write = (xfer0 || xfer1) && (sel_addr != ZR);

      state_d   = WRITE_IDLE;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         WRITE_IDLE,
         WRITE_ISSUE: begin
            // The stage is one deep and drains every cycle, so both states
            // accept a new write; a new transfer keeps it in ISSUE back to back.
            if (sel_write) begin
               state_d   = WRITE_ISSUE;
               wr_addr_d = sel_addr;
               wr_data_d = sel_data;
            end
         end
         default: state_d = WRITE_IDLE;
      endcase
   end

   // Scoreboard update: retire the write landing this edge, then apply a new mark (newer producer wins)
   always_comb begin
      busy_d = busy_q;
      if (state_q == WRITE_ISSUE) begin
         busy_d[wr_addr_q] = 1'b0;
      end
      if (mark_valid && (mark_addr != ZR)) begin
         busy_d[mark_addr] = 1'b1;
      end
      busy_d[ZR] = 1'b0;
   end

   // State registers; reset flushes the write stage and drops all pending reservations
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q    <= 1'b1;
         state_q   <= WRITE_IDLE;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
      end else begin
         last_q    <= last_d;
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign rf_reg_write      = (state_q == WRITE_ISSUE);
   assign rf_write_register = wr_addr_q;
   assign rf_write_data     = wr_data_q;

   assign busy_a = busy_q[query_a_addr];
   assign busy_b = busy_q[query_b_addr];

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the register file's single write port between two writeback requesters (ALU and memory/load), using round-robin arbitration and a valid/ready handshake. Keeps a 32-entry busy scoreboard so decode can stall on registers whose writes have not yet landed. Sits between the writeback stage and the register file; its registered outputs drive the register file's write_register, write_data and reg_write inputs. The register file's write_clk is tied to this block's clk.

## Interface
- WORD, 64, datapath width; matches the register file word width
- ZR_ADDR, 31, zero-register index (XZR); writes to it are discarded
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- req0_valid  input  1  ALU writeback request
- req0_addr  input  5  ALU destination register
- req0_data  input  WORD  ALU result
- req0_ready  output  1  ALU request accepted this cycle; combinational
- req1_valid / req1_addr / req1_data / req1_ready  same widths  memory writeback requester
- rf_write_register  output  5  to the register file's write_register; registered
- rf_write_data  output  WORD  to the register file's write_data; registered
- rf_reg_write  output  1  to the register file's reg_write; registered, one-cycle pulse per write
- mark_valid  input  1  decode issues an instruction that will write mark_addr
- mark_addr  input  5  destination being reserved
- query_a_addr, query_b_addr  input  5  source registers decode wants to read
- busy_a, busy_b  output  1  the queried register has a pending write; combinational from the scoreboard

## Operation
- Arbiter state: one-bit `last` pointer. It holds the requester granted most recently. Reset value is 1, so req0 wins first.
- Grant rules, evaluated combinationally each cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester that is not `last`.
  - Neither valid: no grant; `last` is unchanged.
- reqN_ready = grant to N. A transfer happens when valid and ready are both high at the clock edge. `last` updates to the granted index on each transfer.
- Requesters hold addr and data stable while valid is high and ready is low. A requester must not drop valid before its transfer.
- Write stage register (state WRITE_IDLE / WRITE_ISSUE):
  - On a transfer with addr != ZR_ADDR: the next edge loads rf_write_register and rf_write_data, and sets rf_reg_write=1.
  - Otherwise rf_reg_write=0 on the next edge.
  - A transfer to ZR_ADDR completes the handshake but produces no write pulse.
- Scoreboard: `busy[31:0]`, all cleared on reset.
  - Set: mark_valid && mark_addr != ZR_ADDR sets busy[mark_addr].
  - Clear: while rf_reg_write is high (the register file samples the write at that edge), busy[rf_write_register] is cleared at the same edge.
  - Set and clear of the same index at the same edge: set wins, because a newer producer has been issued.
  - busy[ZR_ADDR] is always 0.
- busy_a = busy[query_a_addr]; busy_b = busy[query_b_addr]. Querying ZR_ADDR always returns 0.
- The scheduler does not check that a writer marked the register beforehand. An unmarked write is still performed, and clears nothing extra.

## Timing
- Reset values: rf_reg_write=0, rf_write_register=0, rf_write_data=0, busy all 0, last=1. Both ready outputs follow the valid inputs, so they can be high in the first cycle after reset.
- Reset asserted mid-operation: the write stage is flushed at that edge with no pulse, and pending writes are lost. Both requesters must be re-driven after reset.
- Latency, for a transfer at edge N:
  - rf_reg_write is high during cycle N..N+1.
  - The register file stores the data at edge N+1.
  - busy clears at edge N+1, so a read issued after N+1 sees the new value.
- Throughput: one write per cycle. Back-to-back transfers produce consecutive rf_reg_write pulses with no bubble.
- Under sustained contention the grants strictly alternate: at most one cycle of wait per pending request.
- A mark at edge M makes busy visible from cycle M+1.

## Test plan
- Reset, then req0 valid alone with addr 5, data 0xAA: req0_ready=1 in the same cycle. The next cycle shows rf_reg_write=1, rf_write_register=5, rf_write_data=0xAA; the cycle after that, rf_reg_write=0.
- Both requesters valid continuously for 4 cycles (req0→r1, req1→r2): grants go req0, req1, req0, req1. The write pulses appear in that order with no gaps.
- Mark r7 at edge M, query_a=r7: busy_a=1 from M+1. req1 writes r7, transfer at edge N: busy_a stays 1 through cycle N and drops after edge N+1.
- Transfer to addr 31: the handshake completes but no rf_reg_write pulse occurs. mark_addr=31 leaves busy_a=0 for query 31.
- Same-edge set and clear: a write to r3 retiring at the same edge as a new mark of r3 leaves busy[3]=1.
- Assert reset while a write pulse is pending: rf_reg_write=0 after that edge, all busy bits clear, and req0 gets the next grant.
